// File: rtl/debounce_multi.sv
// N-channel debouncer: each channel publishes a level once its input has been stable for MAX_VAL clocks.
// Optional macro DEBOUNCE_SYNC_EN adds a 2-flop synchroniser in front of every channel.
module debounce_multi #(
    parameter int CHANNELS  = 4,
    parameter int MAX_VAL   = 20,
    parameter bit RESET_VAL = 1'b0
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic [CHANNELS-1:0] in,
    output logic [CHANNELS-1:0] r_out,
    output logic [CHANNELS-1:0] rise_out,
    output logic [CHANNELS-1:0] fall_out,
    output logic [CHANNELS-1:0] busy_out
);

    localparam int                  CW    = $clog2(MAX_VAL + 1);
    localparam logic [CW-1:0]       MAX_C = CW'(MAX_VAL);
    localparam logic [CW-1:0]       ONE_C = CW'(1);
    localparam logic [CW-1:0]       ZERO_C = CW'(0);
    localparam logic [CHANNELS-1:0] RST_V = {CHANNELS{RESET_VAL}};

    logic [CHANNELS-1:0] sample_s;
    logic [CHANNELS-1:0] hist_r;
    logic [CHANNELS-1:0] hist_next_s;
    logic [CHANNELS-1:0] accept_s;
    logic [CHANNELS-1:0] out_next_s;
    logic [CW-1:0]       cnt_r      [CHANNELS];
    logic [CW-1:0]       cnt_next_s [CHANNELS];

`ifdef DEBOUNCE_SYNC_EN
    logic [CHANNELS-1:0] sync1_r;
    logic [CHANNELS-1:0] sync2_r;

    // Two-flop synchroniser for asynchronous pins.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sync1_r <= RST_V;
            sync2_r <= RST_V;
        end else begin
            sync1_r <= in;
            sync2_r <= sync1_r;
        end
    end

    assign sample_s = sync2_r;
`else
    assign sample_s = in;
`endif

    // Per-channel stability counter; a new level is accepted only with a saturated count.
    always_comb begin
        hist_next_s = hist_r;
        accept_s    = {CHANNELS{1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_next_s[i] = cnt_r[i];
            if (sample_s[i] != hist_r[i]) begin
                cnt_next_s[i]  = ZERO_C;
                hist_next_s[i] = sample_s[i];
            end else if (cnt_r[i] != MAX_C) begin
                cnt_next_s[i] = cnt_r[i] + ONE_C;
            end else begin
                accept_s[i] = (sample_s[i] != r_out[i]);
            end
        end
    end

    assign out_next_s = (r_out & ~accept_s) | (sample_s & accept_s);

    // State and registered outputs; reset discards any partial count.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_r[i] <= ZERO_C;
            end
            hist_r   <= RST_V;
            r_out    <= RST_V;
            rise_out <= {CHANNELS{1'b0}};
            fall_out <= {CHANNELS{1'b0}};
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_r[i] <= cnt_next_s[i];
            end
            hist_r   <= hist_next_s;
            r_out    <= out_next_s;
            rise_out <= accept_s & sample_s;
            fall_out <= accept_s & ~sample_s;
        end
    end

    // Busy is combinational from the counters so it drops the cycle the count saturates.
    always_comb begin
        busy_out = {CHANNELS{1'b1}};
        for (int i = 0; i < CHANNELS; i++) begin
            busy_out[i] = (cnt_r[i] != MAX_C);
        end
    end

endmodule
